// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared edge- or center-aligned carrier,
// double-buffered period/duty/mode with transfer at carrier boundaries.
module pwm_multi #(
  parameter int unsigned PWM_SIZE = 16,
  parameter int unsigned NUM_CH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       center_mode,
  input  logic [PWM_SIZE-1:0]        pwm_period,
  input  logic [NUM_CH*PWM_SIZE-1:0] pwm_duty,
  input  logic [NUM_CH-1:0]          pwm_invert,
  input  logic                       load,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic                       period_start,
  output logic                       update_ack
);

  localparam int unsigned CW = PWM_SIZE;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  typedef logic [NUM_CH-1:0][CW-1:0] duty_arr_t;

  logic [CW-1:0] cnt_q, cnt_d;
  dir_t          dir_q, dir_d;

  logic [CW-1:0] period_act, period_sh;
  duty_arr_t     duty_act, duty_sh;
  logic          center_act, center_sh;
  logic          pending;

  logic [CW-1:0]     period_eff_c;
  duty_arr_t         duty_eff_c;
  logic              center_eff_c;
  logic              pending_eff_c;
  logic              boundary_c;
  logic              xfer_ok_c;
  logic              xfer_c;
  logic [CW-1:0]     p_last_c;
  logic [NUM_CH-1:0] raw_c;
  logic [NUM_CH-1:0] out_d;

  // A load in the current cycle overrides the shadow so it can transfer at once
  always_comb begin
    period_eff_c  = load ? pwm_period : period_sh;
    duty_eff_c    = load ? duty_arr_t'(pwm_duty) : duty_sh;
    center_eff_c  = load ? center_mode : center_sh;
    pending_eff_c = load | pending;
  end

  // Carrier next-state: count direction, next counter value, boundary detect
  always_comb begin
    cnt_d      = CNT_ZERO;
    dir_d      = DIR_UP;
    boundary_c = 1'b0;
    xfer_ok_c  = 1'b0;
    p_last_c   = period_act - CNT_ONE;
    if (!en) begin
      // Stopped carrier: hold at zero, accept a pending update immediately
      xfer_ok_c = 1'b1;
    end else if (period_act == CNT_ZERO) begin
      // Idle carrier never wraps, so a pending update is taken right away
      xfer_ok_c = 1'b1;
    end else if (period_act == CNT_ONE) begin
      boundary_c = 1'b1;
    end else if (!center_act) begin
      if (cnt_q >= p_last_c) begin
        boundary_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      case (dir_q)
        DIR_UP: begin
          if (cnt_q >= p_last_c) begin
            // Reverse at the peak; with P=2 the next value is already zero
            if (cnt_q <= CNT_ONE) begin
              boundary_c = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
              dir_d = DIR_DOWN;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DIR_DOWN: begin
          if (cnt_q <= CNT_ONE) begin
            boundary_c = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
            dir_d = DIR_DOWN;
          end
        end
        default: begin
          boundary_c = 1'b1;
        end
      endcase
    end
    xfer_c = (boundary_c | xfer_ok_c) & pending_eff_c;
  end

  // Per-channel compare against the active duty, then live polarity
  always_comb begin
    raw_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      raw_c[c] = (period_active_nz()) && (cnt_q < duty_act[c]);
    end
    out_d = en ? (raw_c ^ pwm_invert) : '0;
  end

  function automatic logic period_active_nz();
    return period_act != CNT_ZERO;
  endfunction

  // Carrier state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Shadow set and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_sh <= CNT_ZERO;
      duty_sh   <= '0;
      center_sh <= 1'b0;
      pending   <= 1'b0;
    end else begin
      period_sh <= period_eff_c;
      duty_sh   <= duty_eff_c;
      center_sh <= center_eff_c;
      pending   <= pending_eff_c & ~xfer_c;
    end
  end

  // Active set, updated only on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_act <= CNT_ZERO;
      duty_act   <= '0;
      center_act <= 1'b0;
    end else if (xfer_c) begin
      period_act <= period_eff_c;
      duty_act   <= duty_eff_c;
      center_act <= center_eff_c;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
      update_ack   <= 1'b0;
    end else begin
      pwm_out      <= out_d;
      period_start <= boundary_c;
      update_ack   <= xfer_c;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: phase-based reference model feeding a
// scoreboard, plus directed waveform-shape checks per scenario.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        center_mode;
  logic [15:0] pwm_period;
  logic [63:0] pwm_duty;
  logic [3:0]  pwm_invert;
  logic        load;
  logic [3:0]  pwm_out;
  logic        period_start;
  logic        update_ack;

  int errors = 0;
  int checks = 0;

  logic [3:0] s_out;
  logic       s_ps;
  logic       s_ack;

  // reference model state: carrier phase instead of counter/direction
  int  m_ph, m_p, sh_p;
  bit  m_c, sh_c, m_pend;
  int  m_d[4];
  int  sh_d[4];
  logic [5:0] exp_q[$];

  pwm_multi #(.PWM_SIZE(16), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .center_mode(center_mode),
    .pwm_period(pwm_period), .pwm_duty(pwm_duty), .pwm_invert(pwm_invert),
    .load(load), .pwm_out(pwm_out), .period_start(period_start),
    .update_ack(update_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_ph = 0; m_p = 0; sh_p = 0; m_c = 0; sh_c = 0; m_pend = 0;
    for (int c = 0; c < 4; c++) begin m_d[c] = 0; sh_d[c] = 0; end
    exp_q.delete();
  endtask

  function automatic int m_count();
    if (m_p <= 1) return 0;
    if (!m_c) return m_ph;
    return (m_ph < m_p) ? m_ph : 2 * (m_p - 1) - m_ph;
  endfunction

  // Predict the outputs of the coming edge and push them to the scoreboard
  task automatic model_step();
    int cnt, len, e_p;
    bit e_c, pend_eff, bnd, start, xfer;
    int e_d[4];
    logic [3:0] eo;
    cnt = m_count();
    len = (m_p <= 1) ? 1 : (m_c ? 2 * (m_p - 1) : m_p);
    for (int c = 0; c < 4; c++)
      eo[c] = en ? (((m_p != 0) && (cnt < m_d[c])) ^ pwm_invert[c]) : 1'b0;
    e_p = load ? int'(pwm_period) : sh_p;
    e_c = load ? center_mode : sh_c;
    for (int c = 0; c < 4; c++) e_d[c] = load ? int'(pwm_duty[c*16 +: 16]) : sh_d[c];
    pend_eff = load | m_pend;
    if (!en || m_p == 0) begin
      start = 0; bnd = 1; m_ph = 0;
    end else begin
      start = (m_ph == len - 1); bnd = start; m_ph = start ? 0 : m_ph + 1;
    end
    xfer = bnd && pend_eff;
    sh_p = e_p; sh_c = e_c; sh_d = e_d;
    m_pend = pend_eff && !xfer;
    if (xfer) begin m_p = e_p; m_c = e_c; m_d = e_d; end
    exp_q.push_back({eo, start, xfer});
  endtask

  // One clock: predict, clock, sample on falling edge, score
  task automatic cycle();
    logic [5:0] e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    s_out = pwm_out; s_ps = period_start; s_ack = update_ack;
    e = exp_q.pop_front();
    checks++;
    if ({pwm_out, period_start, update_ack} !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t: got out=%b ps=%b ack=%b, expected out=%b ps=%b ack=%b",
               $time, pwm_out, period_start, update_ack, e[5:2], e[1], e[0]);
    end
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
    pwm_duty = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endtask

  task automatic do_load();
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!s_ack && n < 60) begin cycle(); n++; end
    checks++;
    if (s_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s: update_ack got %b, expected 1 within 60 cycles", name, s_ack);
    end
  endtask

  task automatic wait_count(input int target);
    int n = 0;
    while (m_count() != target && n < 60) begin cycle(); n++; end
  endtask

  // Cycles to the next period_start, counting ch0 high samples on the way
  task automatic measure(output int gap, output int highs);
    gap = 0; highs = 0;
    do begin
      cycle(); gap++; highs += int'(s_out[0]);
    end while (!s_ps && gap < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; center_mode = 1'b0; pwm_period = '0;
    pwm_duty = '0; pwm_invert = '0; load = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({pwm_out, period_start, update_ack} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 000000", {pwm_out, period_start, update_ack});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int hi[4];
    int ps;
    en = 1'b1; pwm_period = 16'd10; set_duty(0, 3, 10, 12);
    do_load();
    checks++;
    if (s_ack !== 1'b1) begin
      errors++; $display("FAIL basic_ack: got %b, expected 1", s_ack);
    end
    cycle();
    for (int c = 0; c < 4; c++) hi[c] = 0;
    ps = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      for (int c = 0; c < 4; c++) hi[c] += int'(s_out[c]);
      ps += int'(s_ps);
    end
    checks++;
    if (hi[0] !== 0)  begin errors++; $display("FAIL basic_ch0_high: got %0d, expected 0", hi[0]); end
    checks++;
    if (hi[1] !== 3)  begin errors++; $display("FAIL basic_ch1_high: got %0d, expected 3", hi[1]); end
    checks++;
    if (hi[2] !== 10) begin errors++; $display("FAIL basic_ch2_high: got %0d, expected 10", hi[2]); end
    checks++;
    if (hi[3] !== 10) begin errors++; $display("FAIL basic_ch3_high: got %0d, expected 10", hi[3]); end
    checks++;
    if (ps !== 1)     begin errors++; $display("FAIL basic_period_start: got %0d, expected 1", ps); end
  endtask

  task automatic test_reload();
    int gap, highs;
    set_duty(5, 5, 5, 5);
    do_load();
    wait_ack("reload_first");
    measure(gap, highs);
    checks++;
    if (gap !== 10) begin errors++; $display("FAIL reload_gap10: got %0d, expected 10", gap); end
    checks++;
    if (highs !== 5) begin errors++; $display("FAIL reload_high5: got %0d, expected 5", highs); end
    // Two loads inside one period: only the later one may take effect
    wait_count(2);
    pwm_period = 16'd7; set_duty(1, 1, 1, 1);
    do_load();
    wait_count(4);
    pwm_period = 16'd20; set_duty(8, 8, 8, 8);
    do_load();
    wait_ack("reload_second");
    checks++;
    if (s_ps !== 1'b1) begin errors++; $display("FAIL reload_ack_ps: got %b, expected 1", s_ps); end
    measure(gap, highs);
    checks++;
    if (gap !== 20) begin errors++; $display("FAIL reload_gap20: got %0d, expected 20", gap); end
    checks++;
    if (highs !== 8) begin errors++; $display("FAIL reload_high8: got %0d, expected 8", highs); end
  endtask

  task automatic test_center();
    int gap, highs;
    center_mode = 1'b1; pwm_period = 16'd5; set_duty(2, 2, 2, 2);
    do_load();
    wait_ack("center_ack");
    measure(gap, highs);
    checks++;
    if (gap !== 8) begin errors++; $display("FAIL center_gap: got %0d, expected 8", gap); end
    checks++;
    if (highs !== 3) begin errors++; $display("FAIL center_high: got %0d, expected 3", highs); end
  endtask

  task automatic test_small_period();
    int ps, hi;
    for (int m = 0; m < 2; m++) begin
      center_mode = 1'(m); pwm_period = 16'd1; set_duty(2, 2, 2, 2);
      do_load();
      wait_ack("p1_ack");
      ps = 0;
      for (int i = 0; i < 5; i++) begin cycle(); ps += int'(s_ps); end
      checks++;
      if (ps !== 5) begin errors++; $display("FAIL p1_mode%0d_ps: got %0d, expected 5", m, ps); end
      pwm_period = 16'd0;
      do_load();
      wait_ack("p0_ack");
      ps = 0; hi = 0;
      for (int i = 0; i < 5; i++) begin cycle(); ps += int'(s_ps); hi += int'(s_out != 4'b0); end
      checks++;
      if (ps !== 0) begin errors++; $display("FAIL p0_mode%0d_ps: got %0d, expected 0", m, ps); end
      checks++;
      if (hi !== 0) begin errors++; $display("FAIL p0_mode%0d_out: got %0d high cycles, expected 0", m, hi); end
    end
  endtask

  task automatic test_invert_en();
    center_mode = 1'b0; pwm_period = 16'd10; set_duty(0, 0, 0, 0);
    do_load();
    wait_ack("inv_ack");
    cycle(); cycle();
    pwm_invert = 4'b0001;
    cycle();
    checks++;
    if (s_out[0] !== 1'b1) begin errors++; $display("FAIL invert_on: got %b, expected 1", s_out[0]); end
    pwm_invert = 4'b0000;
    cycle();
    checks++;
    if (s_out[0] !== 1'b0) begin errors++; $display("FAIL invert_off: got %b, expected 0", s_out[0]); end
    wait_count(2);
    pwm_period = 16'd6; set_duty(3, 3, 3, 3);
    do_load();
    pwm_invert = 4'hF; en = 1'b0;
    cycle();
    checks++;
    if (s_ack !== 1'b1) begin errors++; $display("FAIL en0_ack: got %b, expected 1", s_ack); end
    checks++;
    if (s_out !== 4'b0) begin errors++; $display("FAIL en0_out: got %b, expected 0000", s_out); end
    en = 1'b1; pwm_invert = 4'h0;
    cycle(); cycle();
  endtask

  task automatic test_async_reset();
    int acks, hi;
    wait_count(2);
    pwm_period = 16'd9;
    do_load();
    checks++;
    if (s_out !== 4'hF) begin errors++; $display("FAIL prereset_out: got %b, expected 1111", s_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_out, period_start, update_ack} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b, expected 000000", {pwm_out, period_start, update_ack});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    acks = 0; hi = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(); acks += int'(s_ack); hi += int'(s_out != 4'b0);
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL postreset_ack: got %0d, expected 0", acks); end
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL postreset_out: got %0d high cycles, expected 0", hi); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_center();
    test_small_period();
    test_invert_en();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 The block SHALL have parameter PWM_SIZE, default 16, giving the counter, period and duty width in bits.
REQ-002 The block SHALL have parameter NUM_CH, default 4, giving the number of PWM channels sharing one counter.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 Port en  input  1  run enable.
REQ-006 Port center_mode  input  1  carrier select: 0 = edge-aligned sawtooth, 1 = center-aligned triangle.
REQ-007 Port pwm_period  input  PWM_SIZE  requested period P.
REQ-008 Port pwm_duty  input  NUM_CH*PWM_SIZE  requested duties; channel c SHALL use bits [c*PWM_SIZE +: PWM_SIZE].
REQ-009 Port pwm_invert  input  NUM_CH  per-channel output polarity, applied live (not shadowed).
REQ-010 Port load  input  1  single-cycle strobe that captures pwm_period, pwm_duty and center_mode into the shadow set.
REQ-011 Port pwm_out  output  NUM_CH  registered PWM outputs.
REQ-012 Port period_start  output  1  registered one-cycle pulse, high in the cycle the counter is 0 following a boundary.
REQ-013 Port update_ack  output  1  registered one-cycle pulse, high in the first cycle the active set holds newly transferred values.

Function
REQ-014 Two register sets SHALL exist: shadow (written by load) and active (drives counter and compare); a pending flag SHALL be set by load.
REQ-015 A boundary SHALL be any cycle in which the counter's next value is 0 by normal counting.
REQ-016 At a boundary with pending=1, the active set SHALL take the shadow values, pending SHALL clear, and update_ack SHALL pulse the next cycle.
REQ-017 With en=0: counter SHALL be held at 0, direction SHALL be up, pwm_out SHALL be 0, period_start SHALL be 0, and a pending shadow SHALL transfer on the next edge with update_ack pulsing.
REQ-018 A load in the same cycle as a boundary SHALL transfer the newly captured values at that boundary.
REQ-019 A second load while pending=1 SHALL overwrite the shadow; only the latest values SHALL transfer.
REQ-020 Edge mode: counter SHALL count 0..P-1 then wrap to 0, giving a carrier period of P cycles.
REQ-021 Center mode (P>=2): counter SHALL count up 0..P-1, then down P-2..0, reversing at P-1 and at 0, giving a carrier period of 2*(P-1) cycles.
REQ-022 With active P=0, counter SHALL stay 0, all pwm_out SHALL be 0 before inversion, and no boundary SHALL occur except via en=0.
REQ-023 With active P=1, counter SHALL stay 0 and every cycle SHALL be a boundary, in either mode.
REQ-024 Per channel, pwm_out[c] SHALL be registered as (counter < duty_act[c]) XOR pwm_invert[c], one cycle after the counter value.
REQ-025 duty_act[c]=0 SHALL give constant low; duty_act[c]>=P SHALL give constant high (before inversion).
REQ-026 All comparisons SHALL be unsigned PWM_SIZE-bit; the counter SHALL never exceed P-1.

Reset
REQ-027 While rst_n=0: counter 0, direction up, active and shadow sets 0, pending 0, pwm_out 0, period_start 0, update_ack 0.
REQ-028 Assertion mid-period SHALL discard any pending update; after release the block SHALL run with P=0 until a load transfers.

Verification
REQ-029 Reset release, en=1, load P=10, duties {0,3,10,12} -> update_ack 1 cycle later; pwm_out per period: ch0 never high, ch1 high 3 of 10, ch2 and ch3 always high.
REQ-030 Running P=10 duty 5; load P=20 duty 8 at counter=4 -> old waveform completes; new values apply from the next counter=0 with update_ack; period_start spacing changes 10 -> 20.
REQ-031 center_mode=1, P=5, duty 2 -> counter sequence 0,1,2,3,4,3,2,1,0...; period_start every 8 cycles; output high 3 of 8 cycles.
REQ-032 P=1 and P=0, in both modes -> period_start every cycle for P=1; counter 0 and no period_start for P=0.
REQ-033 pwm_invert toggled mid-period -> output flips on the next edge; en=0 forces pwm_out 0 and transfers a pending load immediately.
REQ-034 rst_n asserted asynchronously mid-period with a load pending -> outputs 0 without a clock edge; pending is lost after release.
